// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_e       : converter FSM states
//   BCD_MAX       : largest legal BCD digit
//   is_bcd_digit  : 1 when a nibble is a legal decimal digit
//   bin_width     : minimum binary width holding any DIGITS-digit decimal value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_digit(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

  // ceil(log2(10^digits)); 10^digits is never a power of two, so $clog2 is exact.
  function automatic int unsigned bin_width(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_x10_add.sv
// One Horner step: sum = acc*10 + digit, truncated to BIN_W bits.
//   acc       : running binary accumulator
//   digit     : next BCD nibble
//   sum       : acc*10 + digit (mod 2^BIN_W)
//   digit_bad : digit is not a legal BCD digit (> 9)
module bcd_x10_add
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] sum,
  output logic             digit_bad
);

  // x10 as x8 + x2; illegal digits still go through the arithmetic.
  assign sum       = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_bad = !is_bcd_digit(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
//   in_clk, in_rst         : clock, synchronous active-high reset
//   in_valid, out_up_ready : upstream handshake for in_bcd
//   in_bcd                 : packed BCD word, digit DIGITS-1 in the top nibble
//   out_valid, in_dn_ready : downstream handshake for out_bin/out_err
//   out_bin                : converted value, all ones if any nibble was > 9
//   out_err                : at least one nibble was > 9
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  out_up_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  in_dn_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err
);

  localparam int unsigned      CNT_W    = $clog2(DIGITS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   shreg_q, shreg_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [BIN_W-1:0]      out_bin_q, out_bin_d;
  logic                  out_err_q, out_err_d;

  logic [3:0]            digit;
  logic [BIN_W-1:0]      sum;
  logic                  digit_bad;

  assign digit = shreg_q[4*DIGITS-1 -: 4];

  bcd_x10_add #(
    .BIN_W (BIN_W)
  ) u_x10_add (
    .acc       (acc_q),
    .digit     (digit),
    .sum       (sum),
    .digit_bad (digit_bad)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_bcd;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d   = sum;
        err_d   = err_q | digit_bad;
        shreg_d = shreg_q << 4;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Result registers load with the final step so outputs stay glitch-free.
          out_bin_d = err_d ? '1 : sum;
          out_err_d = err_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (in_dn_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_up_ready = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_bin      = out_bin_q;
  assign out_err      = out_err_q;

  // Too narrow a BIN_W wraps silently in hardware; flag it in simulation.
  always_ff @(posedge in_clk) begin
    assert (BIN_W >= bin_width(DIGITS))
      else $error("bcd_to_bin: BIN_W=%0d below minimum %0d", BIN_W, bin_width(DIGITS));
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        up_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        dn_ready;
  logic [13:0] out_bin;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  bcd_to_bin #(
    .DIGITS (4),
    .BIN_W  (14)
  ) dut (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_valid     (in_valid),
    .out_up_ready (up_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .in_dn_ready  (dn_ready),
    .out_bin      (out_bin),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // {out_valid, out_err, up_ready, out_bin} while idle after reset.
  localparam logic [16:0] IDLE_VEC = {1'b0, 1'b0, 1'b1, 14'd0};

  // Present one word with dn_ready=1 and check latency, result and return to IDLE.
  task automatic run_word(input string tag, input logic [15:0] bcd,
                          input logic [13:0] exp_bin, input logic exp_err);
    chk({tag, "_ready_before"}, 32'(up_ready), 32'd1);
    in_valid = 1'b1;
    in_bcd   = bcd;
    tick();                                   // E0: accept
    in_valid = 1'b0;
    in_bcd   = 16'h0000;
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // E1..E3
      chk({tag, "_conv_vld_rdy"}, 32'({out_valid, up_ready}), 32'd0);
    end
    tick();                                   // E4
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_bin"}, 32'(out_bin), 32'(exp_bin));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    tick();                                   // handshake edge
    chk({tag, "_back_idle"}, 32'({out_valid, up_ready}), 32'b01);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bcd   = 16'h0000;
    dn_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", 32'({out_valid, out_err, up_ready, out_bin}), 32'(IDLE_VEC));
      tick();
    end

    run_word("w1234", 16'h1234, 14'd1234, 1'b0);
    run_word("w0000", 16'h0000, 14'd0,    1'b0);
    run_word("w9999", 16'h9999, 14'd9999, 1'b0);
    run_word("w0009", 16'h0009, 14'd9,    1'b0);
    run_word("w12A4", 16'h12A4, 14'h3FFF, 1'b1);
    run_word("w0042", 16'h0042, 14'd42,   1'b0);

    // Backpressure: hold result for 5 cycles while a new word is offered.
    dn_ready = 1'b0;
    in_valid = 1'b1;
    in_bcd   = 16'h0500;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_bin", 32'(out_bin), 32'd500);
    in_valid = 1'b1;
    in_bcd   = 16'h0999;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", 32'({out_valid, up_ready, out_err, out_bin}), 32'({3'b100, 14'd500}));
    end
    in_valid = 1'b0;
    in_bcd   = 16'h0000;
    dn_ready = 1'b1;
    tick();
    chk("bp_release", 32'({out_valid, up_ready}), 32'b01);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_no_ghost", 32'(out_valid), 32'd0);
    end

    // Reset during the second CONV cycle of 16'h7777.
    in_valid = 1'b1;
    in_bcd   = 16'h7777;
    tick();                                   // E0
    in_valid = 1'b0;
    tick();                                   // E1, now in second CONV cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_state", 32'({out_valid, out_err, up_ready, out_bin}), 32'(IDLE_VEC));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_mid_no_valid", 32'(out_valid), 32'd0);
    end
    run_word("w0001", 16'h0001, 14'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
